// File: rtl/void_display_task.sv
// Formatted-display trace engine: renders a 32-bit word as HEX, DEC, BIN or ASCII, one character per clock.
// Define VOID_DISPLAY_PRINT_EN to route characters to the simulator console; otherwise emit_char is empty.
module void_display_task (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [1:0]  format_sel,
    input  logic        display_en,
    output logic        display_busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CONV,
        EMIT,
        DONE
    } state_t;

    localparam logic [1:0] FMT_HEX = 2'b00;
    localparam logic [1:0] FMT_DEC = 2'b01;
    localparam logic [1:0] FMT_BIN = 2'b10;
    localparam logic [1:0] FMT_ASC = 2'b11;

    localparam logic [4:0] CONV_LAST = 5'd31;
    localparam logic [7:0] CHAR_NL   = 8'h0A;

    state_t      state;
    state_t      state_nx;

    logic [31:0] data_r;
    logic [1:0]  fmt_r;
    logic [39:0] bcd_r;
    logic [5:0]  char_cnt;
    logic [4:0]  conv_cnt;

    logic        emit_vld;
    logic [7:0]  emit_byte;
    logic [3:0]  dec_digit;
    logic [71:0] dabble_shift;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h37 + {4'h0, nib};
    endfunction

    function automatic logic [7:0] ascii_char(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E)
            return b;
        else
            return 8'h2E;
    endfunction

    // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
    function automatic logic [39:0] dabble_adjust(input logic [39:0] bcd);
        logic [39:0] r;
        r = bcd;
        for (int i = 0; i < 10; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [5:0] last_index(input logic [1:0] fmt);
        case (fmt)
            FMT_HEX: return 6'd7;
            FMT_DEC: return 6'd9;
            FMT_BIN: return 6'd31;
            default: return 6'd3;
        endcase
    endfunction

    function void emit_char(input byte c);
`ifdef VOID_DISPLAY_PRINT_EN
        $write("%c", c);
`endif
    endfunction

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (display_en) state_nx = LOAD;
            LOAD: state_nx = (fmt_r == FMT_DEC) ? CONV : EMIT;
            CONV: if (conv_cnt == CONV_LAST) state_nx = EMIT;
            EMIT: if (char_cnt == 6'd0) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dec_digit = 4'h0;
        for (int i = 0; i < 10; i++) begin
            if (char_cnt == i[5:0])
                dec_digit = bcd_r[i*4 +: 4];
        end
    end

    always_comb begin
        emit_vld  = (state == EMIT) || (state == DONE);
        emit_byte = CHAR_NL;
        if (state == EMIT) begin
            case (fmt_r)
                FMT_HEX: emit_byte = hex_char(data_r[{char_cnt[2:0], 2'b00} +: 4]);
                FMT_DEC: emit_byte = {4'h3, dec_digit};
                FMT_BIN: emit_byte = data_r[char_cnt[4:0]] ? 8'h31 : 8'h30;
                FMT_ASC: emit_byte = ascii_char(data_r[{char_cnt[1:0], 3'b000} +: 8]);
                default: emit_byte = CHAR_NL;
            endcase
        end
    end

    assign dabble_shift = {dabble_adjust(bcd_r), data_r} << 1;

    // Control state: FSM, counters and the registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            display_busy <= 1'b0;
            char_cnt     <= '0;
            conv_cnt     <= '0;
        end else begin
            state        <= state_nx;
            display_busy <= (state_nx != IDLE);
            case (state)
                LOAD: begin
                    char_cnt <= last_index(fmt_r);
                    conv_cnt <= '0;
                end
                CONV: conv_cnt <= conv_cnt + 5'd1;
                EMIT: if (char_cnt != 6'd0) char_cnt <= char_cnt - 6'd1;
                default: ;
            endcase
        end
    end

    // Datapath: request latch and the shared double-dabble shift register.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (display_en) begin
                    data_r <= data_in;
                    fmt_r  <= format_sel;
                end
            end
            LOAD: bcd_r <= '0;
            CONV: begin
                bcd_r  <= dabble_shift[71:32];
                data_r <= dabble_shift[31:0];
            end
            default: ;
        endcase
    end

    // A reset edge abandons the line, so nothing is emitted on it.
    always_ff @(posedge clk) begin
        if (!rst && emit_vld)
            emit_char(emit_byte);
    end

endmodule

// File: tb/tb_void_display_task.sv
// Directed bench for void_display_task: table of formatted requests plus hand-written multi-cycle sequences.
module tb_void_display_task;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic [1:0]  format_sel;
    logic        display_en;
    logic        display_busy;

    int checks;
    int failures;

    string cur_line;
    string last_line;
    int    nl_count;
    logic       pend_vld;
    logic [7:0] pend_ch;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  fmt;
        string       line;
        int          busy;
    } vec_t;

    vec_t vecs[10];

    void_display_task dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .format_sel   (format_sel),
        .display_en   (display_en),
        .display_busy (display_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Character stream reconstruction: sample mid-cycle, commit on the edge unless reset wins.
    always @(negedge clk) begin
        pend_vld = dut.emit_vld;
        pend_ch  = dut.emit_byte;
    end

    always @(posedge clk) begin
        if (pend_vld === 1'b1 && rst === 1'b0) begin
            if (pend_ch == 8'h0A) begin
                last_line = cur_line;
                cur_line  = "";
                nl_count++;
            end else begin
                cur_line = $sformatf("%s%c", cur_line, pend_ch);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int n0;
        int cyc;
        n0         = nl_count;
        cyc        = 0;
        data_in    = v.data;
        format_sel = v.fmt;
        display_en = 1'b1;
        @(negedge clk);
        display_en = 1'b0;
        while (display_busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check_int({name, "_busy_len"}, cyc, v.busy);
        check_str({name, "_line"}, last_line, v.line);
        check_int({name, "_newlines"}, nl_count - n0, 1);
    endtask

    initial begin
        int n0;
        int cyc;
        int lowc;
        int extra;

        checks     = 0;
        failures   = 0;
        cur_line   = "";
        last_line  = "";
        nl_count   = 0;
        pend_vld   = 1'b0;
        pend_ch    = 8'h00;
        rst        = 1'b1;
        display_en = 1'b0;
        data_in    = 32'h0;
        format_sel = 2'b00;

        vecs[0] = '{32'hABCD1234, 2'b00, "ABCD1234", 10};
        vecs[1] = '{32'd987654321, 2'b01, "0987654321", 44};
        vecs[2] = '{32'hFFFFFFFF, 2'b01, "4294967295", 44};
        vecs[3] = '{32'hAACCF0AA, 2'b10, "10101010110011001111000010101010", 34};
        vecs[4] = '{{8'd72, 8'd101, 8'd108, 8'd111}, 2'b11, "Helo", 6};
        vecs[5] = '{32'h41000A7F, 2'b11, "A...", 6};
        vecs[6] = '{32'h0F0E00FF, 2'b00, "0F0E00FF", 10};
        vecs[7] = '{32'h00000000, 2'b01, "0000000000", 44};
        vecs[8] = '{32'h80000001, 2'b10, "10000000000000000000000000000001", 34};
        vecs[9] = '{32'h7E207E1F, 2'b11, "~ ~.", 6};

        repeat (3) @(negedge clk);
        check_int("reset_busy", int'(display_busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check_int("idle_busy", int'(display_busy), 0);
        check_int("idle_no_output", nl_count, 0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Inputs change and a second pulse arrive mid-request; both must be ignored.
        n0         = nl_count;
        data_in    = 32'h12345678;
        format_sel = 2'b00;
        display_en = 1'b1;
        @(negedge clk);
        display_en = 1'b0;
        cyc        = 0;
        while (display_busy && cyc < 100) begin
            cyc++;
            if (cyc == 3) begin
                data_in    = 32'hDEADBEEF;
                format_sel = 2'b01;
                display_en = 1'b1;
            end else begin
                display_en = 1'b0;
            end
            @(negedge clk);
        end
        display_en = 1'b0;
        check_int("midreq_busy_len", cyc, 10);
        check_str("midreq_line", last_line, "12345678");
        extra = 0;
        repeat (50) begin
            @(negedge clk);
            if (display_busy) extra++;
        end
        check_int("midreq_no_second_busy", extra, 0);
        check_int("midreq_newlines", nl_count - n0, 1);

        // Reset during the 5th EMIT cycle of a BIN request.
        n0         = nl_count;
        cur_line   = "";
        data_in    = 32'hAACCF0AA;
        format_sel = 2'b10;
        display_en = 1'b1;
        @(negedge clk);
        display_en = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_int("rst_mid_busy", int'(display_busy), 0);
        check_str("rst_mid_partial", cur_line, "1010");
        check_int("rst_mid_no_newline", nl_count - n0, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_str("rst_mid_no_more_chars", cur_line, "1010");
        check_int("rst_mid_idle", int'(display_busy), 0);
        cur_line = "";
        run_vec(vecs[0], "after_rst");
        @(negedge clk);

        // Reset and request together: reset wins.
        rst        = 1'b1;
        display_en = 1'b1;
        data_in    = 32'h11111111;
        format_sel = 2'b00;
        @(negedge clk);
        check_int("rst_en_busy0", int'(display_busy), 0);
        @(negedge clk);
        check_int("rst_en_busy1", int'(display_busy), 0);
        rst        = 1'b0;
        display_en = 1'b0;
        @(negedge clk);
        check_int("rst_en_released", int'(display_busy), 0);

        // display_en held high: restart one cycle after busy falls.
        n0         = nl_count;
        data_in    = 32'hCAFE0042;
        format_sel = 2'b00;
        display_en = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (display_busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check_int("b2b_first_len", cyc, 10);
        lowc = 0;
        while (!display_busy && lowc < 20) begin
            lowc++;
            @(negedge clk);
        end
        check_int("b2b_gap", lowc, 1);
        display_en = 1'b0;
        cyc = 0;
        while (display_busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check_int("b2b_second_len", cyc, 10);
        check_str("b2b_line", last_line, "CAFE0042");
        check_int("b2b_newlines", nl_count - n0, 2);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/void_display_task.md
# void_display_task

Formatted-display engine for simulation and debug: accepts a 32-bit word with a format select and, one character per clock, renders it as hexadecimal, decimal, binary or ASCII text. Character output goes through an internal void function that writes to the simulator console. It sits beside datapath blocks as a register-level trace port. A busy flag lets the driver sequence requests without a FIFO.

## Interface
- No parameters. Widths are fixed: 32-bit data, 2-bit format select.
- Reset is synchronous and active-high; clock is `clk`, reset is `rst`.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous active-high reset.
- data_in  in  32  word to display; sampled only on accept.
- format_sel  in  2  format, sampled on accept:
  - 00 = HEX
  - 01 = DEC (unsigned)
  - 10 = BIN
  - 11 = ASCII
- display_en  in  1  request; one-cycle pulse or level.
- display_busy  out  1  high while a request is in progress; reset value 0.

## Operation
- States and transitions:
  - IDLE: waiting for a request.
  - LOAD: latch data and format.
  - CONV: DEC only.
  - EMIT: output characters.
  - DONE: end the line.
- Accept: in IDLE with display_en=1 at a rising edge, latch data_in into data_r and format_sel into fmt_r, then go to LOAD.
- display_en is ignored in every state except IDLE. Requests made while busy are dropped, not queued.
- LOAD (1 cycle):
  - DEC goes to CONV.
  - All other formats go to EMIT with char_cnt = N-1.
  - N = 8 (HEX), 10 (DEC), 32 (BIN), 4 (ASCII).
- CONV (DEC only, exactly 32 cycles): iterative double-dabble turns data_r into 10 BCD digits in a 40-bit register. It shifts one bit per cycle, and any digit ≥5 gets +3 before the shift.
- EMIT emits one character per cycle, most significant first:
  - HEX: nibble → '0'-'9', 'A'-'F' (uppercase).
  - DEC: BCD digit → '0'-'9'. Always 10 digits, zero-padded (987654321 → "0987654321").
  - BIN: bit → '0'/'1'. 32 characters, no separators.
  - ASCII: byte b[31:24] first. Bytes 0x20-0x7E print as-is; any other byte prints as '.'.
- Leave EMIT after the character with char_cnt = 0 has been emitted.
- DONE (1 cycle): emits a newline, then returns to IDLE.
- A character is emitted by calling the void function `emit_char(input byte c)` at the clock edge that ends the EMIT cycle.
- Reset mid-operation:
  - All state returns to IDLE and display_busy goes to 0 at that edge.
  - The partial line is abandoned: no newline is emitted and no further characters follow.
- If rst and display_en are high together, reset wins.

## Timing
- Accept edge T: display_busy is 1 from T until the edge that leaves DONE.
- display_busy is a registered output, so it rises in the cycle after display_en is seen.
- Busy duration, counted as LOAD + CONV + EMIT + DONE:
  - HEX: 1+0+8+1 = 10 cycles.
  - DEC: 1+32+10+1 = 44 cycles.
  - BIN: 1+0+32+1 = 34 cycles.
  - ASCII: 1+0+4+1 = 6 cycles.
- Back-to-back: a new request can be accepted on the first edge where the state is IDLE. display_en held high therefore restarts a request one cycle after busy falls.
- Changing data_in or format_sel after the accept edge has no effect on the request in progress.

## Configuration
- Macro VOID_DISPLAY_PRINT_EN:
  - Defined: `emit_char` calls `$write("%c", c)`, so each request produces one console line.
  - Undefined: `emit_char` has an empty body.
- The FSM, counters, conversion and display_busy timing are identical in both builds.
- The verification build defines the macro. Synthesis builds do not.

## Test plan
- HEX: data_in=32'hABCD1234, format_sel=00, one-cycle display_en pulse → busy for 10 cycles, console line "ABCD1234".
- DEC: data_in=32'd987654321, format_sel=01 → busy for 44 cycles, line "0987654321". Corner case: data_in=32'hFFFFFFFF → "4294967295".
- BIN: data_in=32'hAACCF0AA, format_sel=10 → busy for 34 cycles, line "10101010110011001111000010101010".
- ASCII: data_in={8'd72,8'd101,8'd108,8'd111}, format_sel=11 → busy for 6 cycles, line "Helo". Also data_in=32'h41000A7F → "A...".
- Pulse display_en and change data_in 3 cycles into a HEX request → the original line is unchanged and no second request runs.
- Assert rst in the 5th EMIT cycle of a BIN request → display_busy=0 at that edge, output stops after 4 characters with no newline, and the next request works normally.
